// File: rtl/alu_operand_stage.sv
// ALU operand stage: forwarding mux, B-source select, one-deep output register.
// Define ALU_OPERAND_FWD_EN to enable EX/MEM and MEM/WB operand forwarding.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [15:0]       imm,
  input  logic [1:0]        alu_src,
  input  logic              exmem_we,
  input  logic              memwb_we,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [1:0] SRC_RF = 2'b00;
  localparam logic [1:0] SRC_EX = 2'b01;
  localparam logic [1:0] SRC_WB = 2'b10;

  logic              load;
  logic              ex_a, wb_a, ex_b, wb_b;
  logic [DATA_W-1:0] a_val, rt_val, b_val;
  logic [1:0]        a_tag, b_tag;

  assign in_ready = !out_valid || out_ready;
  assign load     = in_valid && in_ready && !flush;

`ifdef ALU_OPERAND_FWD_EN
  assign ex_a = exmem_we && (exmem_rd == rs_addr)
             && (rs_addr != '0);
  assign wb_a = memwb_we && (memwb_rd == rs_addr)
             && (rs_addr != '0);
  assign ex_b = exmem_we && (exmem_rd == rt_addr)
             && (rt_addr != '0);
  assign wb_b = memwb_we && (memwb_rd == rt_addr)
             && (rt_addr != '0);
`else
  logic unused_fwd;
  assign unused_fwd = &{1'b0, exmem_we, memwb_we,
                        exmem_rd, memwb_rd,
                        exmem_data, memwb_data};
  assign ex_a = 1'b0;
  assign wb_a = 1'b0;
  assign ex_b = 1'b0;
  assign wb_b = 1'b0;
`endif

  // Pick operand sources; EX/MEM is younger so it wins.
  always_comb begin
    a_val  = rs_data;
    a_tag  = SRC_RF;
    rt_val = rt_data;
    b_tag  = SRC_RF;
    if (ex_a) begin
      a_val = exmem_data;
      a_tag = SRC_EX;
    end else if (wb_a) begin
      a_val = memwb_data;
      a_tag = SRC_WB;
    end
    if (ex_b) begin
      rt_val = exmem_data;
      b_tag  = SRC_EX;
    end else if (wb_b) begin
      rt_val = memwb_data;
      b_tag  = SRC_WB;
    end
  end

  // Select B: register, sign/zero-extended imm or shamt.
  always_comb begin
    b_val = rt_val;
    unique case (1'b1)
      alu_src == 2'b00: b_val = rt_val;
      alu_src == 2'b01:
        b_val = {{(DATA_W-16){imm[15]}}, imm};
      alu_src == 2'b10:
        b_val = {{(DATA_W-16){1'b0}}, imm};
      alu_src == 2'b11:
        b_val = {{(DATA_W-5){1'b0}}, imm[10:6]};
      default: b_val = rt_val;
    endcase
  end

  // Output register; flush only drops valid, data holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      fwd_a     <= SRC_RF;
      fwd_b     <= SRC_RF;
    end else if (load) begin
      out_valid <= 1'b1;
      op_a      <= a_val;
      op_b      <= b_val;
      fwd_a     <= a_tag;
      fwd_b     <= b_tag;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed cases then random traffic
// against a behavioural operand model.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs_addr = '0, rt_addr = '0;
  logic [31:0] rs_data = '0, rt_data = '0;
  logic [15:0] imm = '0;
  logic [1:0]  alu_src = '0;
  logic        exmem_we = 1'b0, memwb_we = 1'b0;
  logic [4:0]  exmem_rd = '0, memwb_rd = '0;
  logic [31:0] exmem_data = '0, memwb_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] op_a, op_b;
  logic [1:0]  fwd_a, fwd_b;

  int vectors = 0;
  int errs = 0;

  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0, m_b = '0;
  logic [1:0]  m_fa = '0, m_fb = '0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data),
    .imm(imm), .alu_src(alu_src),
    .exmem_we(exmem_we), .memwb_we(memwb_we),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_data(exmem_data), .memwb_data(memwb_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void fwd(input logic [4:0] a,
                              input logic [31:0] d,
                              output logic [31:0] v,
                              output logic [1:0] t);
    v = d;
    t = 2'd0;
`ifdef ALU_OPERAND_FWD_EN
    if (a != 0 && exmem_we && exmem_rd == a) begin
      v = exmem_data; t = 2'd1;
    end else if (a != 0 && memwb_we && memwb_rd == a) begin
      v = memwb_data; t = 2'd2;
    end
`endif
  endfunction

  task automatic check_out(input string tag);
    chk({tag, ".valid"}, {31'b0, out_valid}, {31'b0, m_valid});
    chk({tag, ".op_a"}, op_a, m_a);
    chk({tag, ".op_b"}, op_b, m_b);
    chk({tag, ".fwd"}, {28'b0, fwd_a, fwd_b},
        {28'b0, m_fa, m_fb});
  endtask

  task automatic tick(input string tag);
    logic [31:0] b;
    logic        ld;
    #1;
    chk({tag, ".in_ready"}, {31'b0, in_ready},
        {31'b0, (!m_valid || out_ready)});
    @(posedge clk);
    ld = in_valid && (!m_valid || out_ready) && !flush;
    if (!rst_n) begin
      m_valid = 0; m_a = 0; m_b = 0; m_fa = 0; m_fb = 0;
    end else if (ld) begin
      fwd(rs_addr, rs_data, m_a, m_fa);
      fwd(rt_addr, rt_data, b, m_fb);
      case (alu_src)
        2'd0: m_b = b;
        2'd1: m_b = 32'(signed'(imm));
        2'd2: m_b = 32'(imm);
        default: m_b = 32'((imm >> 6) & 16'h1f);
      endcase
      m_valid = 1;
    end else if (flush || out_ready) begin
      m_valid = 0;
    end
    #1;
    check_out(tag);
  endtask

  task automatic no_fwd();
    exmem_we = 0; memwb_we = 0;
    exmem_rd = 0; memwb_rd = 0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 check_out("reset");
    @(negedge clk);
    rst_n = 1'b1;

    in_valid = 1; rs_addr = 3; rs_data = 32'h11;
    rt_addr = 4; rt_data = 32'h22; alu_src = 0;
    no_fwd(); out_ready = 1;
    tick("basic");
    chk("basic.a_const", op_a, 32'h11);
    chk("basic.b_const", op_b, 32'h22);

    imm = 16'h8004; alu_src = 2'b01;
    tick("sext");
    chk("sext.const", op_b, 32'hFFFF8004);
    alu_src = 2'b10;
    tick("zext");
    chk("zext.const", op_b, 32'h00008004);
    imm = 16'h0140; alu_src = 2'b11;
    tick("shamt");
    chk("shamt.const", op_b, 32'd5);

    alu_src = 0; rs_addr = 7; rs_data = 32'h1234;
    exmem_we = 1; exmem_rd = 7; exmem_data = 32'hAAAA;
    memwb_we = 1; memwb_rd = 7; memwb_data = 32'hBBBB;
    tick("fwd_ex");
`ifdef ALU_OPERAND_FWD_EN
    chk("fwd_ex.const", op_a, 32'hAAAA);
`else
    chk("fwd_ex.const", op_a, 32'h1234);
`endif
    exmem_we = 0;
    tick("fwd_wb");
    rs_addr = 0; exmem_we = 1; exmem_rd = 0; memwb_rd = 0;
    tick("fwd_r0");
    chk("fwd_r0.const", {30'b0, fwd_a}, 32'd0);
    no_fwd();

    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      rs_addr = 5'(i + 1); rs_data = 32'h100 + i;
      tick("stall");
    end
    chk("stall.in_ready", {31'b0, in_ready}, 32'd0);
    out_ready = 1; rs_data = 32'h5555;
    tick("drain_load");

    flush = 1; out_ready = 0; rs_data = 32'h6666;
    tick("flush");
    flush = 0; out_ready = 1; in_valid = 1;
    tick("reload");
    out_ready = 0; rs_data = 32'h7777;
    tick("hold");
    #2 rst_n = 1'b0;
    m_valid = 0; m_a = 0; m_b = 0; m_fa = 0; m_fb = 0;
    #1 check_out("async_rst");
    tick("in_rst");
    rst_n = 1'b1; out_ready = 1; rs_data = 32'h8888;
    tick("post_rst");

    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 7) == 0);
      rs_addr    = 5'($urandom_range(0, 7));
      rt_addr    = 5'($urandom_range(0, 7));
      rs_data    = $urandom;
      rt_data    = $urandom;
      imm        = 16'($urandom);
      alu_src    = 2'($urandom_range(0, 3));
      exmem_we   = 1'($urandom_range(0, 1));
      memwb_we   = 1'($urandom_range(0, 1));
      exmem_rd   = 5'($urandom_range(0, 7));
      memwb_rd   = 5'($urandom_range(0, 7));
      exmem_data = $urandom;
      memwb_data = $urandom;
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; SHALL be >= 16.
REQ-002 Parameter REG_AW, default 5, register-address width.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 in_valid  input  1  operand request present.
REQ-006 in_ready  output  1  stage accepts request this cycle.
REQ-007 rs_addr, rt_addr  input  REG_AW  source register numbers.
REQ-008 rs_data, rt_data  input  DATA_W  register-file read data.
REQ-009 imm  input  16  instruction immediate field.
REQ-010 alu_src  input  2  B select: 00 rt, 01 sign-ext imm, 10 zero-ext imm, 11 shamt.
REQ-011 exmem_we, memwb_we  input  1  later-stage write enables.
REQ-012 exmem_rd, memwb_rd  input  REG_AW  later-stage destination registers.
REQ-013 exmem_data, memwb_data  input  DATA_W  later-stage results.
REQ-014 flush  input  1  discard held and incoming operands.
REQ-015 out_valid  output  1  op_a/op_b valid.
REQ-016 out_ready  input  1  consumer accepts operands.
REQ-017 op_a, op_b  output  DATA_W  registered ALU operands.
REQ-018 fwd_a, fwd_b  output  2  registered source tag: 00 regfile, 01 EX/MEM, 10 MEM/WB.

Function
REQ-019 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-020 Transfer SHALL occur on rising clk when in_valid && in_ready && !flush; op_a, op_b, fwd_a, fwd_b load and out_valid sets, latency exactly one cycle.
REQ-021 When out_valid && !out_ready, all outputs SHALL hold unchanged regardless of inputs.
REQ-022 When out_valid && out_ready and no transfer, out_valid SHALL clear next cycle; op_a/op_b hold last value.
REQ-023 Forwarded A: exmem_data if exmem_we && exmem_rd==rs_addr && rs_addr!=0; else memwb_data under same rule with memwb; else rs_data; EX/MEM SHALL win when both match.
REQ-024 Forwarded B (rt) SHALL follow REQ-023 rule using rt_addr.
REQ-025 op_b SHALL be: forwarded B (00); imm[15] replicated to DATA_W (01); imm zero-extended (10); imm[10:6] zero-extended (11).
REQ-026 fwd_b SHALL report the rt forwarding source even when alu_src!=00.
REQ-027 Register 0 SHALL never be forwarded; always rs_data/rt_data, tag 00.
REQ-028 flush SHALL clear out_valid next edge and block same-cycle capture; op_a/op_b SHALL hold.
REQ-029 Simultaneous drain and load (out_valid, out_ready, in_valid) SHALL replace contents, out_valid stays 1.

Reset
REQ-030 rst_n low SHALL immediately force out_valid=0, op_a=0, op_b=0, fwd_a=00, fwd_b=00, independent of clk.
REQ-031 Reset mid-transfer SHALL drop the held operand; first post-release capture occurs on first edge with rst_n high.

Configuration
REQ-032 Macro ALU_OPERAND_FWD_EN defined: forwarding per REQ-023..027.
REQ-033 Macro undefined: exmem_*/memwb_* ignored, A=rs_data, B=rt_data, fwd_a=fwd_b=00; handshake, immediate selection unchanged.

Verification
REQ-034 rs=3 rs_data=0x11, rt=4 rt_data=0x22, alu_src=00, no forwarding, out_ready=1 -> next cycle op_a=0x11, op_b=0x22, fwd 00/00, out_valid=1.
REQ-035 imm=0x8004: alu_src=01 -> op_b=0xFFFF8004; 10 -> 0x00008004; 11 (imm=0x0140) -> op_b=5.
REQ-036 rs=7, exmem_we=1 rd=7 data=0xAAAA, memwb_we=1 rd=7 data=0xBBBB -> op_a=0xAAAA, fwd_a=01; rs=0 with rd=0 -> op_a=rs_data, fwd_a=00.
REQ-037 out_ready=0 three cycles with new in_valid each cycle -> in_ready=0, op_a/op_b frozen; out_ready=1 -> drain and load same edge, out_valid stays 1.
REQ-038 flush=1 with in_valid=1, out_valid=1 -> out_valid=0 next cycle, no capture; rst_n low mid-hold -> all outputs 0 asynchronously.
REQ-039 Macro undefined, REQ-036 stimulus -> op_a=rs_data, fwd_a=00.
